param_fifo: RTL and testbench

Parametrised synchronous FIFO. It is the next generation of the 8x10 flow-control FIFO used in front of the arbiter/demux stages.
Width, depth and programmable almost-full/almost-empty thresholds are generic, with inferred storage in place of an external dual-port RAM.
It adds a full flag, an occupancy count, a valid strobe on read data, sticky overflow/underflow errors and an optional drop-null-word mode.
Instances sit between packet-producing stages and the downstream arbiter, which uses alm_full/alm_empty for back-pressure.

---
 rtl/param_fifo.sv | 94 +++++++++
 tb/tb_param_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, registered read data with a valid strobe, and sticky error flags.
module param_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3,
  parameter int DROP_ZERO  = 1,
  parameter int DEF_SUP    = 6,
  parameter int DEF_INF    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   um_sup,
  input  logic [ADDR_WIDTH:0]   um_inf,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  alm_full,
  output logic                  alm_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         threshold_sup;
  logic [CW-1:0]         threshold_inf;
  logic                  null_word;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags depend only on occupancy and thresholds; a threshold above DEPTH
  // simply never matches.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign alm_full  = (count >= threshold_sup);
  assign alm_empty = (count <= threshold_inf);

  assign null_word = (DROP_ZERO != 0) && (data_in == '0);
  assign pop_ok    = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push_ok   = push && (!full || pop_ok) && !null_word;

  // NOTE: storage carries no reset; pointers and count alone define which
  // words are valid, so clearing the array would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (!init && push_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      threshold_sup <= CW'(DEF_SUP);
      threshold_inf <= CW'(DEF_INF);
    end else if (init) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      threshold_sup <= um_sup;
      threshold_inf <= um_inf;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      valid_out <= pop_ok;
      count     <= count + CW'(push_ok) - CW'(pop_ok);
      if (push && full && !pop && !null_word) overflow <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_param_fifo;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, init, push, pop;
  logic [AW:0]   um_sup, um_inf;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty, alm_full, alm_empty, overflow, underflow;
  logic [AW:0]   count;

  logic          push0, pop0;
  logic [DW-1:0] data_in0, z_data_out;
  logic          z_valid_out, z_full, z_empty, z_alm_full, z_alm_empty, z_overflow, z_underflow;
  logic [AW:0]   z_count;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_ZERO(1), .DEF_SUP(6), .DEF_INF(1)) dut (
    .clk(clk), .reset(reset), .init(init), .push(push), .pop(pop),
    .um_sup(um_sup), .um_inf(um_inf), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .count(count),
    .full(full), .empty(empty), .alm_full(alm_full), .alm_empty(alm_empty),
    .overflow(overflow), .underflow(underflow)
  );

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_ZERO(0), .DEF_SUP(6), .DEF_INF(1)) dut0 (
    .clk(clk), .reset(reset), .init(init), .push(push0), .pop(pop0),
    .um_sup(um_sup), .um_inf(um_inf), .data_in(data_in0),
    .data_out(z_data_out), .valid_out(z_valid_out), .count(z_count),
    .full(z_full), .empty(z_empty), .alm_full(z_alm_full), .alm_empty(z_alm_empty),
    .overflow(z_overflow), .underflow(z_underflow)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a queue plus the visible registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_ovf, m_unf;
  int            m_sup, m_inf;

  task automatic model_reset(input int sup, input int inf);
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_sup   = sup;
    m_inf   = inf;
  endtask

  // Apply this cycle's inputs to the model, then advance the clock.
  task automatic cycle();
    bit was_full, was_empty, drop, pop_ok, push_ok;
    if (init) begin
      model_reset(int'(um_sup), int'(um_inf));
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      drop      = (data_in == 0);
      pop_ok    = pop && !was_empty;
      push_ok   = push && (!was_full || pop_ok) && !drop;
      if (push && was_full && !pop && !drop) m_ovf = 1'b1;
      if (pop && was_empty) m_unf = 1'b1;
      m_valid = pop_ok;
      if (pop_ok) m_data = q.pop_front();
      if (push_ok) q.push_back(data_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init = 0; push = 0; pop = 0; data_in = '0;
    push0 = 0; pop0 = 0; data_in0 = '0;
  endtask

  task automatic do_init(input int sup, input int inf);
    idle_inputs();
    init = 1; um_sup = 4'(sup); um_inf = 4'(inf);
    cycle();
    init = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    um_sup = '0; um_inf = '0;
    reset = 1;
    model_reset(6, 1);
    #2;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    checks++; if (alm_empty !== 1'b1 || alm_full !== 1'b0) begin failures++; $display("FAIL reset_alm got=%b%b exp=10", alm_empty, alm_full); end
    checks++; if (valid_out !== 1'b0 || data_out !== '0) begin failures++; $display("FAIL reset_out got=%b/%h exp=0/000", valid_out, data_out); end
    @(posedge clk); #1;
    reset = 0;
    do_init(6, 1);
    checks++; if (count !== 4'd0 || empty !== 1'b1 || alm_empty !== 1'b1) begin failures++; $display("FAIL init_state got=%0d/%b/%b exp=0/1/1", count, empty, alm_empty); end
    checks++; if (full !== 1'b0 || alm_full !== 1'b0 || valid_out !== 1'b0) begin failures++; $display("FAIL init_flags got=%b%b%b exp=000", full, alm_full, valid_out); end
  endtask

  task automatic test_fill();
    push = 1; pop = 0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      data_in = DW'(i);
      cycle();
      checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      checks++; if (full !== (q.size() == DEPTH)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, q.size() == DEPTH); end
      checks++; if (alm_full !== (q.size() >= m_sup)) begin failures++; $display("FAIL fill_alm_full[%0d] got=%b exp=%b", i, alm_full, q.size() >= m_sup); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL fill_overflow[%0d] got=%b exp=%b", i, overflow, m_ovf); end
    end
    push = 0;
  endtask

  task automatic test_drain();
    pop = 1; push = 0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      cycle();
      checks++; if (valid_out !== m_valid) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, valid_out, m_valid); end
      checks++; if (data_out !== m_data) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, m_data); end
      checks++; if (underflow !== m_unf || empty !== (q.size() == 0)) begin failures++; $display("FAIL drain_flags[%0d] got=%b%b exp=%b%b", i, underflow, empty, m_unf, q.size() == 0); end
    end
    pop = 0;
  endtask

  task automatic test_stream();
    push = 1; pop = 0;
    for (int i = 0; i < 3; i++) begin
      data_in = DW'($urandom_range(1, 1023));
      cycle();
    end
    pop = 1;
    for (int i = 0; i < 20; i++) begin
      data_in = DW'($urandom_range(1, 1023));
      cycle();
      checks++; if (count !== 4'(q.size()) || count !== 4'd3) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=3", i, count); end
      checks++; if (valid_out !== 1'b1 || data_out !== m_data) begin failures++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, valid_out, data_out, m_data); end
    end
    push = 0; pop = 0;
  endtask

  task automatic test_drop_zero();
    do_init(6, 1);
    push = 1;
    for (int i = 0; i < DEPTH; i++) begin
      data_in = (i == 2) ? '0 : DW'(100 + i);
      cycle();
    end
    checks++; if (count !== 4'(q.size()) || count !== 4'd7) begin failures++; $display("FAIL drop_count got=%0d exp=7", count); end
    data_in = 10'h055;
    cycle();
    data_in = '0;
    cycle();
    checks++; if (full !== 1'b1 || overflow !== 1'b0 || m_ovf !== 1'b0) begin failures++; $display("FAIL drop_full_no_ovf got=%b%b exp=10", full, overflow); end
    push = 0;
    // Same stimulus on the instance that stores null words.
    push0 = 1;
    data_in0 = 10'h3ff; @(posedge clk); #1;
    data_in0 = '0;      @(posedge clk); #1;
    push0 = 0;
    checks++; if (z_count !== 4'd2) begin failures++; $display("FAIL keep_zero_count got=%0d exp=2", z_count); end
    pop0 = 1;
    @(posedge clk); #1;
    checks++; if (z_valid_out !== 1'b1 || z_data_out !== 10'h3ff) begin failures++; $display("FAIL keep_zero_rd0 got=%b/%h exp=1/3ff", z_valid_out, z_data_out); end
    @(posedge clk); #1;
    checks++; if (z_valid_out !== 1'b1 || z_data_out !== 10'h000 || z_empty !== 1'b1) begin failures++; $display("FAIL keep_zero_rd1 got=%b/%h/%b exp=1/000/1", z_valid_out, z_data_out, z_empty); end
    pop0 = 0; push0 = 1; data_in0 = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      @(posedge clk); #1;
    end
    push0 = 0;
    checks++; if (z_count !== 4'd8 || z_overflow !== 1'b1) begin failures++; $display("FAIL keep_zero_ovf got=%0d/%b exp=8/1", z_count, z_overflow); end
  endtask

  task automatic test_random();
    do_init(6, 1);
    for (int i = 0; i < 400; i++) begin
      init    = ($urandom_range(0, 59) == 0);
      um_sup  = 4'($urandom_range(0, 10));
      um_inf  = 4'($urandom_range(0, 8));
      push    = ($urandom_range(0, 99) < 55);
      pop     = ($urandom_range(0, 99) < 45);
      data_in = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 1023));
      cycle();
      checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      checks++; if (valid_out !== m_valid || (m_valid && data_out !== m_data)) begin failures++; $display("FAIL rnd_data[%0d] got=%b/%h exp=%b/%h", i, valid_out, data_out, m_valid, m_data); end
      checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_full_empty[%0d] got=%b%b", i, full, empty); end
      checks++; if (alm_full !== (q.size() >= m_sup) || alm_empty !== (q.size() <= m_inf)) begin failures++; $display("FAIL rnd_alm[%0d] got=%b%b exp=%b%b", i, alm_full, alm_empty, q.size() >= m_sup, q.size() <= m_inf); end
      checks++; if (overflow !== m_ovf || underflow !== m_unf) begin failures++; $display("FAIL rnd_err[%0d] got=%b%b exp=%b%b", i, overflow, underflow, m_ovf, m_unf); end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_init(3, 2);
    pop = 1; cycle(); pop = 0;
    push = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(20 + i);
      cycle();
    end
    push = 0;
    checks++; if (count !== 4'd5 || alm_full !== 1'b1 || underflow !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b/%b exp=5/1/1", count, alm_full, underflow); end
    #3 reset = 1;
    model_reset(6, 1);
    #1;
    checks++; if (count !== 4'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%b/%b exp=0/0/0", count, underflow, overflow); end
    @(posedge clk); #1;
    reset = 0;
    push = 1;
    for (int i = 1; i <= 6; i++) begin
      data_in = DW'(40 + i);
      cycle();
      checks++; if (alm_full !== (i >= 6) || alm_empty !== (i <= 1)) begin failures++; $display("FAIL thr_revert[%0d] got=%b%b exp=%b%b", i, alm_full, alm_empty, i >= 6, i <= 1); end
    end
    push = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    um_sup = '0; um_inf = '0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_drop_zero();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
